// File: rtl/pio_rmw_arbiter_if.sv
// Requester-side and PIO-side bus of the read-modify-write arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface pio_rmw_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 11,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] set_mask;
    logic [NUM_REQ*DATA_W-1:0] clr_mask;
    logic [NUM_REQ-1:0]        ack;
    logic                      busy;
    logic [ID_W-1:0]           grant_id;
    logic [1:0]                m_address;
    logic                      m_chipselect;
    logic                      m_write_n;
    logic [31:0]               m_writedata;
    logic [31:0]               m_readdata;

    // Requester handshake: req rises and stays high until its one-cycle ack
    // pulse; it must be low in the cycle after ack, otherwise it is a new
    // request. Masks are sampled only on the edge that grants the request.
    modport slave (
        input  req, set_mask, clr_mask, m_readdata,
        output ack, busy, grant_id, m_address, m_chipselect, m_write_n, m_writedata
    );

    modport master (
        output req, set_mask, clr_mask, m_readdata,
        input  ack, busy, grant_id, m_address, m_chipselect, m_write_n, m_writedata
    );
endinterface

// File: rtl/pio_rmw_arbiter.sv
// Round-robin arbiter performing bit-level set/clear read-modify-write
// updates on a shared Avalon-MM output PIO data register.
module pio_rmw_arbiter #(
    parameter int         NUM_REQ  = 2,
    parameter int         DATA_W   = 11,
    parameter logic [1:0] PIO_ADDR = 2'd0
) (
    input  logic                clk,
    input  logic                reset,
    pio_rmw_arbiter_if.slave    bus,
    output logic [1:0]          o_dbg_state
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ID_W-1:0]     r_grant, w_grant_nxt;
    logic [ID_W-1:0]     r_ptr, w_ptr_nxt;
    logic [DATA_W-1:0]   r_set, w_set_nxt;
    logic [DATA_W-1:0]   r_clr, w_clr_nxt;
    logic [NUM_REQ-1:0]  r_ack, w_ack_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_cs, w_cs_nxt;
    logic                r_wr_n, w_wr_n_nxt;
    logic [31:0]         r_wdata, w_wdata_nxt;
    logic                w_found;
    logic [ID_W-1:0]     w_pick;
    logic [ID_W-1:0]     w_idx;
    logic [DATA_W-1:0]   w_rd;

    assign w_rd = bus.m_readdata[DATA_W-1:0];

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_set_nxt   = r_set;
        w_clr_nxt   = r_clr;
        w_ack_nxt   = '0;
        w_cs_nxt    = 1'b0;
        w_wr_n_nxt  = 1'b1;
        w_wdata_nxt = r_wdata;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = RD;
                    w_grant_nxt = w_pick;
                    w_set_nxt   = bus.set_mask[int'(w_pick)*DATA_W +: DATA_W];
                    w_clr_nxt   = bus.clr_mask[int'(w_pick)*DATA_W +: DATA_W];
                    w_cs_nxt    = 1'b1;
                end
            end
            RD: begin
                // Readdata is combinational, so the merged word is formed
                // directly from it as the read cycle ends; set wins over clear.
                w_state_nxt = WR;
                w_cs_nxt    = 1'b1;
                w_wr_n_nxt  = 1'b0;
                w_wdata_nxt = 32'((w_rd & ~r_clr) | r_set);
            end
            WR: begin
                w_state_nxt        = ACK;
                w_ack_nxt[r_grant] = 1'b1;
            end
            ACK: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_set   <= '0;
            r_clr   <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_cs    <= 1'b0;
            r_wr_n  <= 1'b1;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_set   <= w_set_nxt;
            r_clr   <= w_clr_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
            r_cs    <= w_cs_nxt;
            r_wr_n  <= w_wr_n_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign bus.ack          = r_ack;
    assign bus.busy         = r_busy;
    assign bus.grant_id     = r_grant;
    assign bus.m_address    = PIO_ADDR;
    assign bus.m_chipselect = r_cs;
    assign bus.m_write_n    = r_wr_n;
    assign bus.m_writedata  = r_wdata;
    assign o_dbg_state      = r_state;
endmodule
